board_state_ctrl: RTL and testbench
===================================

Name: board_state_ctrl

Overview:
Game-state writer for the 8x8 minesweeper board. It owns and updates the four 64-bit tile maps (mine, flag, step, cursor position) that the gameboard renderer scans for display. It places mines from a free-running LFSR, moves the cursor, toggles flags, reveals stepped tiles, and detects loss and win. It sits between the debounced button pulse logic and the gameboard renderer.

Parameters:
NUM_MINES, 10, number of mines placed per game; legal range 1..62.
LFSR_SEED, 16'hACE1, reset value of the 16-bit LFSR; must be nonzero.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
btn_up  input  1  single-cycle pulse: move cursor up one row
btn_down  input  1  single-cycle pulse: move cursor down one row
btn_left  input  1  single-cycle pulse: move cursor left one column
btn_right  input  1  single-cycle pulse: move cursor right one column
btn_flag  input  1  single-cycle pulse: toggle flag on cursor tile
btn_step  input  1  single-cycle pulse: step on (reveal) cursor tile
btn_new  input  1  single-cycle pulse: start a new game
mineMap  output  64  bit t = tile t holds a mine
flagMap  output  64  bit t = tile t is flagged
stepMap  output  64  bit t = tile t is revealed
posMap  output  64  one-hot cursor; bit t = cursor on tile t
flag_count  output  7  number of set bits in flagMap
busy  output  1  high while mines are being placed
game_over  output  1  high in LOST
game_won  output  1  high in WON

Behaviour:
- Tile index t[5:0]: t[2:0] = column 0..7, t[5:3] = row 0..7. Tile 0 is top-left.
- All outputs are registered. Reset (async, active-high):
  - mine/flag/step maps = 0; posMap = 64'h1; flag_count = 0.
  - LFSR = LFSR_SEED; state = PLACE; busy = 1; game_over = game_won = 0.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifts every cycle in every state.
- States:
  - PLACE: each cycle, candidate c = lfsr[5:0].
    - If mineMap[c] == 0 and c != cursor tile, set mineMap[c] and increment the placed count.
    - When the placed count reaches NUM_MINES, go to PLAY next cycle.
    - All buttons are ignored in PLACE.
  - PLAY: at most one action per cycle. Priority: btn_new > btn_step > btn_flag > up > down > left > right. Lower-priority pulses in the same cycle are dropped.
    - Moves wrap within the line:
      - left from column 0 goes to column 7; right from column 7 goes to column 0.
      - up from row 0 goes to row 7; down from row 7 goes to row 0.
      - posMap stays one-hot at all times.
    - Flag: toggles flagMap[t] only when stepMap[t] == 0; otherwise no effect. flag_count tracks the toggle on the same edge.
    - Step:
      - Ignored if flagMap[t] == 1 or stepMap[t] == 1.
      - Otherwise set stepMap[t].
      - If mineMap[t] == 1: on the same edge, stepMap <= stepMap | mineMap | (1<<t), state goes to LOST, game_over = 1.
    - Win check uses the registered maps: when (stepMap | mineMap) == all ones in PLAY, go to WON on the next edge and set game_won = 1. WON is therefore entered one cycle after the final safe step.
  - LOST / WON: all maps are frozen. Only btn_new is honoured.
  - btn_new (PLAY/LOST/WON):
    - Clears mine/flag/step maps and flag_count; posMap = 64'h1.
    - Clears game_over and game_won; enters PLACE with busy = 1.
    - Does not reset the LFSR.
- No flood-fill: one step reveals exactly one tile.
- Reset asserted mid-PLACE or mid-game returns immediately to the reset values.
- Guarantees:
  - The cursor tile at placement start (tile 0) is never mined.
  - mineMap never exceeds NUM_MINES bits set.

Test Plan:
- Reset, NUM_MINES=10: busy=1 from reset; within 200 cycles busy=0; popcount(mineMap)=10; mineMap[0]=0; posMap=64'h1.
- From tile 0, pulse btn_left -> posMap=64'h80 (tile 7). Then btn_up -> posMap bit 63 set, all others clear. Then btn_right -> tile 56.
- On unstepped tile 9: btn_flag -> flagMap[9]=1, flag_count=1. btn_step on tile 9 -> no change. btn_flag again -> flagMap[9]=0, flag_count=0.
- Step on a safe tile -> only that stepMap bit sets. Step on a mine tile m -> game_over=1 and stepMap[m]=1 on that edge; stepMap includes all mine bits. Further moves and steps leave all maps unchanged.
- Step every non-mine tile -> game_won=1 exactly one cycle after the last step edge; (stepMap|mineMap)=64'hFFFF_FFFF_FFFF_FFFF.
- btn_step and btn_right in the same cycle on a safe tile -> step applied, cursor unmoved. btn_new in LOST -> maps cleared, busy=1, new layout differs from the previous one.

Source files
------------

// File: rtl/board_state_ctrl_if.sv
// Button pulses in, tile maps and game status out, between the pulse logic and the renderer.
// slave is the board controller; master is whoever drives buttons and consumes the maps.
interface board_state_ctrl_if;
  logic        btn_up;
  logic        btn_down;
  logic        btn_left;
  logic        btn_right;
  logic        btn_flag;
  logic        btn_step;
  logic        btn_new;
  logic [63:0] mineMap;
  logic [63:0] flagMap;
  logic [63:0] stepMap;
  logic [63:0] posMap;
  logic [6:0]  flag_count;
  logic        busy;
  logic        game_over;
  logic        game_won;

  modport slave (
    input  btn_up, btn_down, btn_left, btn_right, btn_flag, btn_step, btn_new,
    output mineMap, flagMap, stepMap, posMap, flag_count, busy, game_over, game_won
  );

  modport master (
    output btn_up, btn_down, btn_left, btn_right, btn_flag, btn_step, btn_new,
    input  mineMap, flagMap, stepMap, posMap, flag_count, busy, game_over, game_won
  );
endinterface

// File: rtl/board_state_ctrl.sv
// Minesweeper 8x8 game-state writer: LFSR mine placement, cursor moves, flag/step, win/loss.
// Tile t: t[2:0] = column, t[5:3] = row; tile 0 is top-left.
module board_state_ctrl #(
  parameter int unsigned NUM_MINES = 10,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input logic               clk,
  input logic               reset,
  board_state_ctrl_if.slave bus
);

  localparam logic [1:0] StPlace = 2'd0;
  localparam logic [1:0] StPlay  = 2'd1;
  localparam logic [1:0] StLost  = 2'd2;
  localparam logic [1:0] StWon   = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [63:0] mine_q, mine_d;
  logic [63:0] flag_q, flag_d;
  logic [63:0] step_q, step_d;
  logic [63:0] pos_q, pos_d;
  logic [5:0]  cur_q, cur_d;
  logic [6:0]  fcnt_q, fcnt_d;
  logic [5:0]  placed_q, placed_d;
  logic        busy_q, busy_d;
  logic        over_q, over_d;
  logic        won_q, won_d;

  logic [5:0]  cand;
  logic [2:0]  row, col;
  logic        do_new;

  assign cand = lfsr_q[5:0];
  assign row  = cur_q[5:3];
  assign col  = cur_q[2:0];

  // Fibonacci taps 16,14,13,11; runs every cycle so each new game gets a fresh layout.
  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  always_comb begin
    state_d  = state_q;
    mine_d   = mine_q;
    flag_d   = flag_q;
    step_d   = step_q;
    cur_d    = cur_q;
    fcnt_d   = fcnt_q;
    placed_d = placed_q;
    busy_d   = busy_q;
    over_d   = over_q;
    won_d    = won_q;
    do_new   = 1'b0;

    unique case (state_q)
      StPlace: begin
        if (!mine_q[cand] && (cand != cur_q)) begin
          mine_d[cand] = 1'b1;
          placed_d     = placed_q + 6'd1;
          if (placed_d == 6'(NUM_MINES)) begin
            state_d = StPlay;
            busy_d  = 1'b0;
          end
        end
      end
      StPlay: begin
        // Win is judged on the registered maps, so it lands one edge after the last safe step.
        if (&(step_q | mine_q)) begin
          state_d = StWon;
          won_d   = 1'b1;
        end else if (bus.btn_new) begin
          do_new = 1'b1;
        end else if (bus.btn_step) begin
          if (!flag_q[cur_q] && !step_q[cur_q]) begin
            step_d[cur_q] = 1'b1;
            if (mine_q[cur_q]) begin
              step_d  = step_q | mine_q | pos_q;
              state_d = StLost;
              over_d  = 1'b1;
            end
          end
        end else if (bus.btn_flag) begin
          if (!step_q[cur_q]) begin
            flag_d[cur_q] = ~flag_q[cur_q];
            fcnt_d        = flag_q[cur_q] ? fcnt_q - 7'd1 : fcnt_q + 7'd1;
          end
        end else if (bus.btn_up) begin
          cur_d = {row - 3'd1, col};
        end else if (bus.btn_down) begin
          cur_d = {row + 3'd1, col};
        end else if (bus.btn_left) begin
          cur_d = {row, col - 3'd1};
        end else if (bus.btn_right) begin
          cur_d = {row, col + 3'd1};
        end
      end
      StLost, StWon: begin
        do_new = bus.btn_new;
      end
    endcase

    if (do_new) begin
      state_d  = StPlace;
      mine_d   = '0;
      flag_d   = '0;
      step_d   = '0;
      cur_d    = '0;
      fcnt_d   = '0;
      placed_d = '0;
      busy_d   = 1'b1;
      over_d   = 1'b0;
      won_d    = 1'b0;
    end

    pos_d = 64'h1 << cur_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StPlace;
      lfsr_q   <= LFSR_SEED;
      mine_q   <= '0;
      flag_q   <= '0;
      step_q   <= '0;
      pos_q    <= 64'h1;
      cur_q    <= '0;
      fcnt_q   <= '0;
      placed_q <= '0;
      busy_q   <= 1'b1;
      over_q   <= 1'b0;
      won_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      mine_q   <= mine_d;
      flag_q   <= flag_d;
      step_q   <= step_d;
      pos_q    <= pos_d;
      cur_q    <= cur_d;
      fcnt_q   <= fcnt_d;
      placed_q <= placed_d;
      busy_q   <= busy_d;
      over_q   <= over_d;
      won_q    <= won_d;
    end
  end

  assign bus.mineMap    = mine_q;
  assign bus.flagMap    = flag_q;
  assign bus.stepMap    = step_q;
  assign bus.posMap     = pos_q;
  assign bus.flag_count = fcnt_q;
  assign bus.busy       = busy_q;
  assign bus.game_over  = over_q;
  assign bus.game_won   = won_q;

endmodule

// File: tb/tb_board_state_ctrl.sv
// Directed + random bench for board_state_ctrl against a row/column board model.
module tb_board_state_ctrl;
  localparam int NUM = 10;
  localparam int PH_PLACE = 0, PH_PLAY = 1, PH_LOST = 2, PH_WON = 3;
  localparam logic [6:0] B_NEW = 7'b1000000, B_STEP = 7'b0100000, B_FLAG = 7'b0010000;
  localparam logic [6:0] B_UP = 7'b0001000, B_DOWN = 7'b0000100, B_LEFT = 7'b0000010;
  localparam logic [6:0] B_RIGHT = 7'b0000001;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  board_state_ctrl_if bus ();

  board_state_ctrl #(
    .NUM_MINES(NUM),
    .LFSR_SEED(16'hACE1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  int m_lfsr, m_row, m_col, m_phase, m_placed;
  bit m_mine[64];
  bit m_flag[64];
  bit m_step[64];

  function automatic logic [63:0] pack(input bit a[64]);
    logic [63:0] v = '0;
    for (int i = 0; i < 64; i++) v[i] = a[i];
    return v;
  endfunction

  function automatic int cur_tile();
    return m_row * 8 + m_col;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 64; i++) begin
      m_mine[i] = 1'b0;
      m_flag[i] = 1'b0;
      m_step[i] = 1'b0;
    end
    m_row = 0;
    m_col = 0;
    m_placed = 0;
    m_phase = PH_PLACE;
  endtask

  task automatic model_reset();
    model_clear();
    m_lfsr = 'hACE1;
  endtask

  function automatic bit all_covered();
    for (int i = 0; i < 64; i++) if (!(m_step[i] || m_mine[i])) return 1'b0;
    return 1'b1;
  endfunction

  // Model of one clock edge given the buttons held during that cycle.
  task automatic model_step(input logic [6:0] b);
    int t = cur_tile();
    int c = m_lfsr % 64;
    int fb;
    case (m_phase)
      PH_PLACE: begin
        if (!m_mine[c] && c != t) begin
          m_mine[c] = 1'b1;
          m_placed++;
          if (m_placed == NUM) m_phase = PH_PLAY;
        end
      end
      PH_PLAY: begin
        if (all_covered()) m_phase = PH_WON;
        else if (b[6]) model_clear();
        else if (b[5]) begin
          if (!m_flag[t] && !m_step[t]) begin
            m_step[t] = 1'b1;
            if (m_mine[t]) begin
              for (int i = 0; i < 64; i++) if (m_mine[i]) m_step[i] = 1'b1;
              m_phase = PH_LOST;
            end
          end
        end
        else if (b[4]) begin
          if (!m_step[t]) m_flag[t] = !m_flag[t];
        end
        else if (b[3]) m_row = (m_row + 7) % 8;
        else if (b[2]) m_row = (m_row + 1) % 8;
        else if (b[1]) m_col = (m_col + 7) % 8;
        else if (b[0]) m_col = (m_col + 1) % 8;
      end
      default: if (b[6]) model_clear();
    endcase
    fb = ((m_lfsr >> 15) ^ (m_lfsr >> 13) ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1;
    m_lfsr = ((m_lfsr << 1) | fb) & 'hFFFF;
  endtask

  task automatic drive(input logic [6:0] b);
    {bus.btn_new, bus.btn_step, bus.btn_flag, bus.btn_up, bus.btn_down, bus.btn_left,
     bus.btn_right} = b;
  endtask

  task automatic compare_all();
    logic [63:0] p = '0;
    int nf = 0;
    p[cur_tile()] = 1'b1;
    for (int i = 0; i < 64; i++) nf += int'(m_flag[i]);
    check("mineMap", bus.mineMap, pack(m_mine));
    check("flagMap", bus.flagMap, pack(m_flag));
    check("stepMap", bus.stepMap, pack(m_step));
    check("posMap", bus.posMap, p);
    check("flag_count", 64'(bus.flag_count), 64'(nf));
    check("busy", 64'(bus.busy), 64'(m_phase == PH_PLACE));
    check("game_over", 64'(bus.game_over), 64'(m_phase == PH_LOST));
    check("game_won", 64'(bus.game_won), 64'(m_phase == PH_WON));
  endtask

  // Called at a negedge; returns at the following negedge with outputs compared.
  task automatic cycle(input logic [6:0] b);
    drive(b);
    model_step(b);
    @(posedge clk);
    @(negedge clk);
    drive('0);
    compare_all();
  endtask

  task automatic wait_place();
    for (int k = 0; k < 200 && m_phase == PH_PLACE; k++) cycle('0);
    check("place_done", 64'(m_phase == PH_PLAY), 64'd1);
    check("busy_low", 64'(bus.busy), 64'd0);
    check("mine_count", 64'($countones(bus.mineMap)), 64'(NUM));
    check("tile0_safe", 64'(bus.mineMap[0]), 64'd0);
  endtask

  task automatic goto_tile(input int t);
    for (int k = 0; k < 8 && m_row != t / 8; k++) cycle(B_DOWN);
    for (int k = 0; k < 8 && m_col != t % 8; k++) cycle(B_RIGHT);
  endtask

  logic [63:0] snap_mine, snap_flag, snap_step;
  logic [6:0]  rb;
  int          s, last, mt;

  initial begin
    reset = 1'b1;
    drive('0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    compare_all();
    check("reset_pos", bus.posMap, 64'h1);
    reset = 1'b0;

    wait_place();
    check("pos_after_place", bus.posMap, 64'h1);

    cycle(B_LEFT);
    check("pos_left_wrap", bus.posMap, 64'h80);
    cycle(B_UP);
    check("pos_up_wrap", bus.posMap, 64'h8000_0000_0000_0000);
    cycle(B_RIGHT);
    check("pos_right_wrap", bus.posMap, 64'h0100_0000_0000_0000);

    goto_tile(9);
    cycle(B_FLAG);
    check("flag9_set", 64'(bus.flagMap[9]), 64'd1);
    check("flag9_count", 64'(bus.flag_count), 64'd1);
    cycle(B_STEP);
    check("step9_blocked", bus.stepMap, 64'd0);
    cycle(B_FLAG);
    check("flag9_clear", 64'(bus.flagMap[9]), 64'd0);
    check("flag9_count0", 64'(bus.flag_count), 64'd0);

    for (int i = 0; i < 300; i++) begin
      rb = 7'($urandom) & 7'($urandom) & 7'b0111111;
      cycle(rb);
    end

    // Winning game; the opening step also carries a right press that must be dropped.
    cycle(B_NEW);
    wait_place();
    s = -1;
    for (int i = 63; i >= 0; i--) if (!m_mine[i]) s = i;
    goto_tile(s);
    cycle(B_STEP | B_RIGHT);
    check("step_only_one", bus.stepMap, 64'h1 << s);
    check("step_no_move", bus.posMap, 64'h1 << s);
    last = s;
    for (int t = 0; t < 64; t++) begin
      if (!m_mine[t] && !m_step[t]) begin
        goto_tile(t);
        cycle(B_STEP);
        last = t;
      end
    end
    check("last_stepped", 64'(bus.stepMap[last]), 64'd1);
    check("won_not_yet", 64'(bus.game_won), 64'd0);
    cycle('0);
    check("won", 64'(bus.game_won), 64'd1);
    check("covered", bus.stepMap | bus.mineMap, 64'hFFFF_FFFF_FFFF_FFFF);

    // Losing game.
    cycle(B_NEW);
    wait_place();
    mt = 0;
    for (int i = 63; i >= 0; i--) if (m_mine[i]) mt = i;
    goto_tile(mt);
    cycle(B_STEP);
    check("lost_over", 64'(bus.game_over), 64'd1);
    check("lost_step_m", 64'(bus.stepMap[mt]), 64'd1);
    check("lost_step_mines", bus.stepMap & pack(m_mine), pack(m_mine));
    snap_mine = pack(m_mine);
    snap_flag = pack(m_flag);
    snap_step = pack(m_step);
    for (int i = 0; i < 12; i++) cycle(7'($urandom) & 7'b0111111);
    check("frozen_mine", bus.mineMap, snap_mine);
    check("frozen_flag", bus.flagMap, snap_flag);
    check("frozen_step", bus.stepMap, snap_step);
    cycle(B_NEW);
    check("new_busy", 64'(bus.busy), 64'd1);
    check("new_cleared", bus.mineMap | bus.stepMap | bus.flagMap, 64'd0);
    check("new_over_clr", 64'(bus.game_over), 64'd0);
    wait_place();
    check("new_layout", 64'(bus.mineMap != snap_mine), 64'd1);

    // Asynchronous reset in the middle of placement.
    cycle(B_NEW);
    cycle('0);
    cycle('0);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("async_rst_mine", bus.mineMap, 64'd0);
    check("async_rst_pos", bus.posMap, 64'h1);
    check("async_rst_busy", 64'(bus.busy), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    wait_place();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
